// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer
// Brief    : Pulses the iCE40 PLL reset, qualifies a synchronized LOCK and
//            falls back to PLL bypass after repeated lock timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
    parameter int RESET_CYCLES        = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       lock_i,
    input  logic       clear_i,
    output logic       pll_resetb_o,
    output logic       pll_bypass_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [3:0] retry_cnt_o,
    output logic [7:0] lost_lock_cnt_o
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RESET   = 3'd1;
    localparam logic [2:0] c_ST_WAIT    = 3'd2;
    localparam logic [2:0] c_ST_QUALIFY = 3'd3;
    localparam logic [2:0] c_ST_READY   = 3'd4;
    localparam logic [2:0] c_ST_FAIL    = 3'd5;

    // One extra bit of headroom so a power-of-two parameter never wraps.
    localparam int c_RST_W = $clog2(RESET_CYCLES + 1);
    localparam int c_STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int c_TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    localparam logic [c_RST_W-1:0] c_RST_LAST    = c_RST_W'(RESET_CYCLES - 1);
    localparam logic [c_STB_W-1:0] c_STB_LAST    = c_STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST    = c_TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         c_MAX_RETRIES = 4'(MAX_RETRIES);

    logic [2:0]         r_state;
    logic [c_RST_W-1:0] r_rst_cnt;
    logic [c_STB_W-1:0] r_stb_cnt;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_lock_meta;
    logic               r_lock_sync;

    logic [2:0]         w_state_nxt;
    logic               w_lock_s;
    logic               w_retry_inc;
    logic               w_lock_lost;

    assign w_lock_s = r_lock_sync;

    // Disable has absolute priority; lock beats a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_lock_lost = 1'b0;
        if (!enable_i) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_nxt = c_ST_RESET;
                end
                c_ST_RESET: begin
                    if (r_rst_cnt == c_RST_LAST) begin
                        w_state_nxt = c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (w_lock_s) begin
                        w_state_nxt = c_ST_QUALIFY;
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        if (retry_cnt_o < c_MAX_RETRIES) begin
                            w_state_nxt = c_ST_RESET;
                            w_retry_inc = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_FAIL;
                        end
                    end
                end
                c_ST_QUALIFY: begin
                    if (!w_lock_s) begin
                        w_state_nxt = c_ST_WAIT;
                    end else if (r_stb_cnt == c_STB_LAST) begin
                        w_state_nxt = c_ST_READY;
                    end
                end
                c_ST_READY: begin
                    if (!w_lock_s) begin
                        w_state_nxt = c_ST_RESET;
                        w_lock_lost = 1'b1;
                    end
                end
                c_ST_FAIL: begin
                    w_state_nxt = c_ST_FAIL;
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= c_ST_IDLE;
            r_rst_cnt       <= '0;
            r_stb_cnt       <= '0;
            r_tmo_cnt       <= '0;
            r_lock_meta     <= 1'b0;
            r_lock_sync     <= 1'b0;
            pll_resetb_o    <= 1'b0;
            pll_bypass_o    <= 1'b0;
            ready_o         <= 1'b0;
            fail_o          <= 1'b0;
            retry_cnt_o     <= 4'd0;
            lost_lock_cnt_o <= 8'd0;
        end else begin
            r_lock_meta <= lock_i;
            r_lock_sync <= r_lock_meta;
            r_state     <= w_state_nxt;

            // Each counter restarts from zero whenever its state is (re)entered.
            r_rst_cnt <= (r_state == c_ST_RESET && w_state_nxt == c_ST_RESET)
                       ? r_rst_cnt + c_RST_W'(1) : '0;
            r_tmo_cnt <= (r_state == c_ST_WAIT && w_state_nxt == c_ST_WAIT)
                       ? r_tmo_cnt + c_TMO_W'(1) : '0;
            r_stb_cnt <= (r_state == c_ST_QUALIFY && w_state_nxt == c_ST_QUALIFY)
                       ? r_stb_cnt + c_STB_W'(1) : '0;

            if ((r_state == c_ST_IDLE && w_state_nxt == c_ST_RESET) ||
                (r_state == c_ST_QUALIFY && w_state_nxt == c_ST_READY)) begin
                retry_cnt_o <= 4'd0;
            end else if (w_retry_inc) begin
                retry_cnt_o <= retry_cnt_o + 4'd1;
            end

            if (clear_i) begin
                lost_lock_cnt_o <= {7'd0, w_lock_lost};
            end else if (w_lock_lost && lost_lock_cnt_o != 8'hFF) begin
                lost_lock_cnt_o <= lost_lock_cnt_o + 8'd1;
            end

            pll_resetb_o <= (w_state_nxt == c_ST_WAIT)    ||
                            (w_state_nxt == c_ST_QUALIFY) ||
                            (w_state_nxt == c_ST_READY);
            pll_bypass_o <= (w_state_nxt == c_ST_FAIL);
            fail_o       <= (w_state_nxt == c_ST_FAIL);
            ready_o      <= (w_state_nxt == c_ST_READY);
        end
    end

endmodule
`default_nettype wire
